isa_io_target: RTL and testbench

ISA-bus I/O responder: the card-side counterpart of the ISA host bridge in the HPS system. It decodes host IOR/IOW cycles in a 16-port window and serves a small register file. It also acts as an 8-bit DMA requester: it streams bytes from a local FIFO to the host through the DRQ/DACK handshake, and raises an IRQ at terminal count. It is used as an on-fabric stand-in card and loopback target when bringing up the riser.

---
 rtl/isa_io_target.sv | 272 +++++++++++++++++++++++++++
 tb/tb_isa_io_target.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isa_io_target.sv
// rtl/isa_io_target.sv - ISA I/O responder: 16-port register window, byte FIFO, 8-bit DMA requester with TC interrupt
module isa_io_target #(
    parameter logic [15:0] BASE_ADDR  = 16'h0220,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic        AEN,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic        IOR,
    input  logic        IOW,
    input  logic        DACK,
    output logic        DRQ,
    output logic        IRQ,
    input  logic        RESET,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IO_RD  = 2'd1,
        S_IO_WR  = 2'd2,
        S_DMA_RD = 2'd3
    } state_t;

    logic ior_s1_q, ior_s2_q, ior_prev_q;
    logic iow_s1_q, iow_s2_q, iow_prev_q;
    logic dack_s1_q, dack_s2_q;
    logic rst_s1_q, rst_s2_q;

    state_t state_q, state_d;
    logic        armed_q, armed_d;
    logic [1:0]  init_q, init_d;
    logic [3:0]  addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  din_q, din_d;
    logic        rd_pop_q, rd_pop_d;
    logic        dma_en_q, dma_en_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_pend_q, irq_pend_d;
    logic [15:0] cnt_q, cnt_d;
    logic        drq_q, drq_d;
    logic        irq_q, irq_d;
    logic [AW:0]   fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;

    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic       ior_fall, ior_rise, iow_fall, iow_rise;
    logic       hit, fifo_empty, fifo_full, push, pop;
    logic       load_rd, latch_wr, commit, dma_step, d_oe_c;
    logic [7:0] head, reg_rdata;

    // Strobe synchronisers idle high so reset never looks like a falling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ior_s1_q   <= 1'b1;
            ior_s2_q   <= 1'b1;
            ior_prev_q <= 1'b1;
            iow_s1_q   <= 1'b1;
            iow_s2_q   <= 1'b1;
            iow_prev_q <= 1'b1;
            dack_s1_q  <= 1'b1;
            dack_s2_q  <= 1'b1;
            rst_s1_q   <= 1'b0;
            rst_s2_q   <= 1'b0;
        end else begin
            ior_s1_q   <= IOR;
            ior_s2_q   <= ior_s1_q;
            ior_prev_q <= ior_s2_q;
            iow_s1_q   <= IOW;
            iow_s2_q   <= iow_s1_q;
            iow_prev_q <= iow_s2_q;
            dack_s1_q  <= DACK;
            dack_s2_q  <= dack_s1_q;
            rst_s1_q   <= RESET;
            rst_s2_q   <= rst_s1_q;
        end
    end

    assign ior_fall = ior_prev_q & ~ior_s2_q;
    assign ior_rise = ~ior_prev_q & ior_s2_q;
    assign iow_fall = iow_prev_q & ~iow_s2_q;
    assign iow_rise = ~iow_prev_q & iow_s2_q;

    assign hit        = ~AEN && (A[15:4] == BASE_ADDR[15:4]) && (A[3:0] <= 4'd5);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == FULL_CNT);
    assign push       = src_valid & ~fifo_full;
    assign src_ready  = ~fifo_full;
    assign head       = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= src_data;
        end
    end

    always_comb begin
        reg_rdata = 8'h00;
        case (A[3:0])
            4'd0:    reg_rdata = head;
            4'd1:    reg_rdata = {4'b0000, irq_pend_q, dma_en_q, fifo_full, fifo_empty};
            4'd2:    reg_rdata = {6'b000000, irq_en_q, dma_en_q};
            4'd3:    reg_rdata = cnt_q[7:0];
            4'd4:    reg_rdata = cnt_q[15:8];
            default: reg_rdata = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        load_rd  = 1'b0;
        latch_wr = 1'b0;
        commit   = 1'b0;
        pop      = 1'b0;
        dma_step = 1'b0;
        d_oe_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (armed_q) begin
                    if (!dack_s2_q && !ior_s2_q) begin
                        state_d = S_DMA_RD;
                    end else if (ior_fall && hit) begin
                        state_d = S_IO_RD;
                        load_rd = 1'b1;
                    end else if (iow_fall && hit) begin
                        state_d  = S_IO_WR;
                        latch_wr = 1'b1;
                    end
                end
            end
            S_IO_RD: begin
                d_oe_c = ~ior_rise;
                if (ior_rise) begin
                    state_d = S_IDLE;
                    pop     = rd_pop_q & ~fifo_empty;
                end
            end
            S_IO_WR: begin
                if (iow_rise) begin
                    state_d = S_IDLE;
                    commit  = 1'b1;
                end
            end
            S_DMA_RD: begin
                d_oe_c = ~ior_rise;
                if (ior_rise) begin
                    state_d  = S_IDLE;
                    pop      = ~fifo_empty;
                    dma_step = ~fifo_empty;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rst_s2_q) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        armed_d    = armed_q | ((init_q == 2'd2) & ior_s2_q & iow_s2_q & dack_s2_q);
        init_d     = (init_q == 2'd2) ? init_q : init_q + 2'd1;
        addr_d     = (load_rd || latch_wr) ? A[3:0] : addr_q;
        dout_d     = load_rd ? reg_rdata : dout_q;
        rd_pop_d   = load_rd ? ((A[3:0] == 4'd0) && !fifo_empty) : rd_pop_q;
        din_d      = (state_q == S_IO_WR) ? D_in : din_q;
        dma_en_d   = dma_en_q;
        irq_en_d   = irq_en_q;
        irq_pend_d = irq_pend_q;
        cnt_d      = cnt_q;
        if (commit) begin
            case (addr_q)
                4'd2: begin
                    dma_en_d = din_q[0];
                    irq_en_d = din_q[1];
                end
                4'd3:    cnt_d[7:0]  = din_q;
                4'd4:    cnt_d[15:8] = din_q;
                4'd5:    irq_pend_d  = 1'b0;
                default: ;
            endcase
        end
        // Terminal count: the 1 -> 0 step stops DMA and raises the interrupt together
        if (dma_step && cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
                dma_en_d   = 1'b0;
                irq_pend_d = 1'b1;
            end
        end
        drq_d    = dma_en_q & ~fifo_empty & (cnt_q != 16'd0) & (state_q != S_DMA_RD);
        irq_d    = irq_pend_q & irq_en_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + (AW + 1)'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - (AW + 1)'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (rst_s2_q) begin
            armed_d    = 1'b0;
            init_d     = 2'd0;
            addr_d     = 4'd0;
            dout_d     = 8'h00;
            rd_pop_d   = 1'b0;
            din_d      = 8'h00;
            dma_en_d   = 1'b0;
            irq_en_d   = 1'b0;
            irq_pend_d = 1'b0;
            cnt_d      = 16'd0;
            drq_d      = 1'b0;
            irq_d      = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fifo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            init_q     <= 2'd0;
            addr_q     <= 4'd0;
            dout_q     <= 8'h00;
            rd_pop_q   <= 1'b0;
            din_q      <= 8'h00;
            dma_en_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            cnt_q      <= 16'd0;
            drq_q      <= 1'b0;
            irq_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            init_q     <= init_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            rd_pop_q   <= rd_pop_d;
            din_q      <= din_d;
            dma_en_q   <= dma_en_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            cnt_q      <= cnt_d;
            drq_q      <= drq_d;
            irq_q      <= irq_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    assign D_oe  = d_oe_c;
    assign D_out = (state_q == S_DMA_RD) ? head : dout_q;
    assign DRQ   = drq_q;
    assign IRQ   = irq_q;

endmodule

// File: tb/tb_isa_io_target.sv
// tb/tb_isa_io_target.sv - scoreboard bench for isa_io_target against a queue-based register/FIFO model
module tb_isa_io_target;

    localparam int          DEPTH = 16;
    localparam logic [15:0] BASE  = 16'h0220;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] A = 16'h0000;
    logic        AEN = 1'b0;
    logic [7:0]  D_in = 8'h00;
    logic [7:0]  D_out;
    logic        D_oe;
    logic        IOR = 1'b1, IOW = 1'b1, DACK = 1'b1;
    logic        DRQ, IRQ;
    logic        RESET = 1'b0;
    logic [7:0]  src_data = 8'h00;
    logic        src_valid = 1'b0;
    logic        src_ready;

    isa_io_target #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .A(A), .AEN(AEN), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
        .IOR(IOR), .IOW(IOW), .DACK(DACK), .DRQ(DRQ), .IRQ(IRQ), .RESET(RESET),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int doe_rises = 0;
    logic doe_prev = 1'b0;
    logic [7:0] exp_q[$];

    // Card model: FIFO as a queue, registers as plain variables
    logic [7:0]  fifo_m[$];
    logic [15:0] cnt_m;
    bit          dma_en_m, irq_en_m, pend_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (D_oe === 1'b1 && doe_prev !== 1'b1) begin
            doe_rises++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: D_out=%0h with no read outstanding", D_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (D_out !== e) begin
                    errors++;
                    $display("FAIL read_data: got %0h expected %0h", D_out, e);
                end
            end
        end
        doe_prev = D_oe;
    end

    function automatic void model_reset();
        fifo_m.delete();
        cnt_m = 16'd0;
        dma_en_m = 0;
        irq_en_m = 0;
        pend_m = 0;
    endfunction

    function automatic bit is_hit(input logic [15:0] addr, input logic aen);
        return !aen && addr[15:4] == BASE[15:4] && addr[3:0] <= 4'd5;
    endfunction

    function automatic logic [7:0] model_read(input logic [3:0] off);
        case (off)
            4'd0: return (fifo_m.size() > 0) ? fifo_m.pop_front() : 8'h00;
            4'd1: return {4'b0, pend_m, dma_en_m, fifo_m.size() == DEPTH, fifo_m.size() == 0};
            4'd2: return {6'b0, irq_en_m, dma_en_m};
            4'd3: return cnt_m[7:0];
            4'd4: return cnt_m[15:8];
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_write(input logic [3:0] off, input logic [7:0] d);
        case (off)
            4'd2: begin dma_en_m = d[0]; irq_en_m = d[1]; end
            4'd3: cnt_m[7:0] = d;
            4'd4: cnt_m[15:8] = d;
            4'd5: pend_m = 0;
            default: ;
        endcase
    endfunction

    task automatic io_read(input logic [15:0] addr, input logic aen);
        bit hit;
        int r0;
        hit = is_hit(addr, aen);
        r0 = doe_rises;
        @(negedge clk);
        A = addr; AEN = aen; IOR = 1'b0;
        if (hit) exp_q.push_back(model_read(addr[3:0]));
        @(posedge clk); @(posedge clk); #1;
        check("doe_early", D_oe, 1'b0);
        @(posedge clk); #1;
        check("doe_latency", D_oe, hit);
        repeat (3) @(posedge clk);
        @(negedge clk);
        IOR = 1'b1;
        repeat (5) @(posedge clk);
        AEN = 1'b0;
        if (!hit) check("no_claim", doe_rises - r0, 0);
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input logic aen);
        @(negedge clk);
        A = addr; AEN = aen; D_in = data; IOW = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        IOW = 1'b1;
        repeat (5) @(posedge clk);
        AEN = 1'b0;
        if (is_hit(addr, aen)) model_write(addr[3:0], data);
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        check("src_ready", src_ready, fifo_m.size() < DEPTH);
        src_data = b; src_valid = 1'b1;
        @(posedge clk);
        if (fifo_m.size() < DEPTH) fifo_m.push_back(b);
        #1 src_valid = 1'b0;
    endtask

    // DATA read whose closing edge coincides with pushes; pop lands on the third push edge
    task automatic read_with_push(input logic [7:0] base_d);
        bit do_pop;
        @(negedge clk);
        A = BASE; AEN = 1'b0; IOR = 1'b0;
        do_pop = fifo_m.size() > 0;
        exp_q.push_back(do_pop ? fifo_m[0] : 8'h00);
        repeat (6) @(posedge clk);
        @(negedge clk);
        IOR = 1'b1; src_valid = 1'b1; src_data = base_d;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            if (fifo_m.size() < DEPTH) fifo_m.push_back(src_data);
            if (i == 2 && do_pop) void'(fifo_m.pop_front());
            #1 src_data = src_data + 8'd1;
        end
        src_valid = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic dma_cycle();
        @(negedge clk);
        AEN = 1'b1; A = 16'($urandom); DACK = 1'b0; IOR = 1'b0;
        exp_q.push_back(fifo_m.size() > 0 ? fifo_m[0] : 8'h00);
        repeat (5) @(posedge clk); #1;
        check("drq_in_dma", DRQ, 1'b0);
        @(negedge clk);
        IOR = 1'b1; DACK = 1'b1;
        repeat (5) @(posedge clk);
        AEN = 1'b0;
        if (fifo_m.size() > 0) begin
            void'(fifo_m.pop_front());
            if (cnt_m != 0) begin
                cnt_m = cnt_m - 1;
                if (cnt_m == 0) begin dma_en_m = 0; pend_m = 1; end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        repeat (3) @(posedge clk); #1;
        check({tag, "_drq"}, DRQ, dma_en_m && fifo_m.size() > 0 && cnt_m != 0);
        check({tag, "_irq"}, IRQ, pend_m && irq_en_m);
        check({tag, "_src_ready"}, src_ready, fifo_m.size() < DEPTH);
    endtask

    task automatic start_dma_and_hold();
        @(negedge clk);
        AEN = 1'b1; DACK = 1'b0; IOR = 1'b0;
        exp_q.push_back(fifo_m.size() > 0 ? fifo_m[0] : 8'h00);
        repeat (5) @(posedge clk);
        #1 check("dma_doe", D_oe, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_dout", D_out, 8'h00);
        check("rst_doe", D_oe, 1'b0);
        check("rst_drq", DRQ, 1'b0);
        check("rst_irq", IRQ, 1'b0);
        check("rst_src_ready", src_ready, 1'b1);
        repeat (4) @(posedge clk);

        io_write(16'h0223, 8'h34, 1'b0);
        io_write(16'h0224, 8'h12, 1'b0);
        io_read(16'h0223, 1'b0);
        io_read(16'h0224, 1'b0);
        io_read(16'h0230, 1'b0);
        io_write(16'h0230, 8'h55, 1'b0);
        io_write(16'h0223, 8'h00, 1'b0);
        io_write(16'h0224, 8'h00, 1'b0);

        push_byte(8'hA1);
        push_byte(8'hA2);
        io_read(16'h0221, 1'b0);
        repeat (3) io_read(16'h0220, 1'b0);
        io_read(16'h0221, 1'b0);

        io_write(16'h0223, 8'h02, 1'b0);
        io_write(16'h0224, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        io_write(16'h0222, 8'h03, 1'b0);
        check_outputs("dma_armed");
        dma_cycle();
        dma_cycle();
        check_outputs("dma_tc");
        io_read(16'h0221, 1'b0);
        io_write(16'h0225, 8'hFF, 1'b0);
        check_outputs("irq_ack");
        io_write(16'h0222, 8'h01, 1'b0);
        check_outputs("dma_en_cnt0");
        io_read(16'h0221, 1'b0);
        io_write(16'h0222, 8'h00, 1'b0);
        while (fifo_m.size() > 0) io_read(16'h0220, 1'b0);

        for (int i = 0; i < DEPTH; i++) push_byte(8'h40 + 8'(i));
        check_outputs("full");
        push_byte(8'hEE);
        io_read(16'h0221, 1'b0);
        read_with_push(8'hC0);
        check_outputs("full_pop");
        io_read(16'h0221, 1'b0);
        while (fifo_m.size() > 2) io_read(16'h0220, 1'b0);
        read_with_push(8'hD0);
        while (fifo_m.size() > 0) io_read(16'h0220, 1'b0);
        io_read(16'h0221, 1'b0);

        io_read(16'h0221, 1'b1);

        @(negedge clk);
        reset = 1'b1; IOR = 1'b0; A = 16'h0221;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        r0 = doe_rises;
        repeat (10) @(posedge clk);
        check("held_ior_ignored", doe_rises - r0, 0);
        @(negedge clk);
        IOR = 1'b1;
        repeat (4) @(posedge clk);
        io_read(16'h0221, 1'b0);

        push_byte(8'h5A);
        push_byte(8'h5B);
        io_write(16'h0223, 8'h05, 1'b0);
        io_write(16'h0222, 8'h03, 1'b0);
        check_outputs("pre_rst");
        start_dma_and_hold();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_doe", D_oe, 1'b0);
        check("async_rst_drq", DRQ, 1'b0);
        check("async_rst_dout", D_out, 8'h00);
        IOR = 1'b1; DACK = 1'b1; AEN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        io_read(16'h0221, 1'b0);
        io_read(16'h0223, 1'b0);
        io_read(16'h0222, 1'b0);

        push_byte(8'h6A);
        io_write(16'h0223, 8'h04, 1'b0);
        io_write(16'h0222, 8'h03, 1'b0);
        start_dma_and_hold();
        @(negedge clk);
        RESET = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bus_rst_doe", D_oe, 1'b0);
        check("bus_rst_drq", DRQ, 1'b0);
        @(negedge clk);
        RESET = 1'b0; IOR = 1'b1; DACK = 1'b1; AEN = 1'b0;
        model_reset();
        repeat (6) @(posedge clk);
        io_read(16'h0221, 1'b0);
        io_read(16'h0223, 1'b0);
        io_read(16'h0222, 1'b0);
        check_outputs("bus_rst");

        for (int it = 0; it < 80; it++) begin
            int op;
            op = $urandom_range(0, 5);
            if (op >= 4 && !(dma_en_m && fifo_m.size() > 0 && cnt_m != 0)) op = 0;
            case (op)
                0: repeat ($urandom_range(1, 3)) push_byte(8'($urandom));
                1: begin
                    int off;
                    off = $urandom_range(0, 5);
                    if (off == 2) io_write(BASE + 16'(off), 8'($urandom_range(0, 3)), 1'b0);
                    else if (off == 3) io_write(BASE + 16'(off), 8'($urandom_range(0, 6)), 1'b0);
                    else if (off == 4) io_write(BASE + 16'(off), 8'($urandom_range(0, 1)), 1'b0);
                    else io_write(BASE + 16'(off), 8'($urandom), 1'b0);
                end
                2: io_read(BASE + 16'($urandom_range(0, 5)), 1'b0);
                3: begin
                    case ($urandom_range(0, 2))
                        0: io_read(16'h0230 + 16'($urandom_range(0, 15)), 1'b0);
                        1: io_read(BASE + 16'($urandom_range(0, 5)), 1'b1);
                        default: io_read(BASE + 16'($urandom_range(6, 15)), 1'b0);
                    endcase
                end
                default: dma_cycle();
            endcase
            check_outputs("rand");
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
